mdu_divider: RTL and testbench
==============================

Name: mdu_divider

Overview:
Sequential integer divider for the MIPS datapath. It implements DIV and DIVU, the inverse of the ALU's multiply path, and writes the quotient to Lo and the remainder to Hi. It sits beside the ALU in EX. The controller pulses start, then stalls on busy until done.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of 2, at least 4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a divide; sampled only in IDLE.
Sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
A  input  WIDTH  dividend; captured with start.
B  input  WIDTH  divisor; captured with start.
cancel  input  1  synchronous abort of an in-flight divide.
busy  output  1  high while a divide is in progress.
done  output  1  one-cycle pulse when Hi/Lo are updated.
div_zero  output  1  high with done when B was 0; holds until next start accepted.
Hi  output  WIDTH  remainder register.
Lo  output  WIDTH  quotient register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div_zero=0, Hi=0, Lo=0; counter and work registers cleared.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0: capture Sign, sign(A), sign(B).
  - Load magnitudes: |A| and |B| when Sign=1, raw values otherwise. Magnitude of the most negative value is itself, taken as unsigned.
  - Clear the partial remainder and count; set busy=1, div_zero=0.
  - If B==0: go to FIX directly. Otherwise go to RUN.
- RUN: restoring division, one quotient bit per edge, MSB first.
  - Shift {rem,quo} left 1 and trial-subtract the divisor magnitude.
  - If no borrow: keep the difference, quo LSB=1. Else restore, LSB=0.
  - After WIDTH iterations (edges E1..E32 for WIDTH=32) go to FIX.
- FIX: one edge (E33).
  - Normal: Lo=quo, negated if Sign=1 and signs of A and B differ. Hi=rem, negated if Sign=1 and A was negative.
  - B==0 (entered at E1): Lo=all ones, Hi=A unmodified, div_zero=1.
  - At the FIX edge: done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency:
  - Normal: done visible in the cycle after edge E(WIDTH+1), i.e. 34 cycles after start for WIDTH=32.
  - Divide-by-zero: done visible after E1, i.e. 2 cycles.
- Signed overflow (most-negative / -1): Lo=most-negative value, Hi=0, no flag. This falls out of the magnitude arithmetic.
- Remainder sign always follows the dividend. Quotient truncates toward zero.
- start while busy=1: ignored; operands not recaptured; no queueing.
- start and done in the same cycle: done belongs to the old op. State is IDLE that cycle, so the new start is accepted.
- cancel=1 in RUN or FIX: next edge returns to IDLE with busy=0 and no done. Hi, Lo and div_zero keep their prior values. cancel has priority over FIX completion. cancel in IDLE has no effect and beats a simultaneous start (start is dropped).
- Hi/Lo change only at the FIX edge or reset; they hold between ops.
- rst_n low mid-operation: immediate return to the reset values; no done.
- Unsigned mode: operands are never negated; all WIDTH bits are magnitude.

Test Plan:
- Unsigned 100/7 (Sign=0): busy high 33 cycles, done 34 cycles after start -> Lo=14, Hi=2, div_zero=0.
- Signed -7/2 (A=0xFFFFFFF9, B=2, Sign=1) -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Signed 7/-2 -> Lo=0xFFFFFFFD, Hi=1.
- Overflow and unsigned large: A=0x80000000, B=0xFFFFFFFF, Sign=1 -> Lo=0x80000000, Hi=0. Same operands with Sign=0 -> Lo=0, Hi=0x80000000.
- Divide-by-zero: A=0x12345678, B=0, Sign=1 -> done 2 cycles after start, Lo=0xFFFFFFFF, Hi=0x12345678, div_zero=1. Next accepted start clears div_zero.
- Handshake:
  - start pulsed at cycle 10 of an op with different operands -> ignored, original result returned.
  - start in the done cycle -> new op accepted, busy stays high, second done after 34 more cycles.
- Abort:
  - cancel at iteration 15 -> busy=0 next cycle, no done, Hi/Lo unchanged.
  - rst_n low at iteration 20 -> all outputs 0 immediately; after release, a fresh 9/3 gives Lo=3, Hi=0.

Source files
------------

// File: rtl/mdu_divider.sv
// mdu_divider: sequential restoring DIV/DIVU, quotient to Lo and remainder to Hi
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, mag_a, mag_b;
  logic [WIDTH:0] sh, diff;
  logic sgn, neg_a, neg_b, bz, accept, last;
  assign accept = state == IDLE && start && !cancel;
  assign last = cnt == CW'(WIDTH - 1);
  assign mag_a = Sign && A[WIDTH-1] ? -A : A;
  assign mag_b = Sign && B[WIDTH-1] ? -B : B;
  // shifted remainder needs one extra bit when the divisor exceeds half range
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (B == '0 ? FIX : RUN) : IDLE;
      RUN:     state_n = cancel ? IDLE : (last ? FIX : RUN);
      default: state_n = IDLE;
    endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      bz <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      Hi <= '0;
      Lo <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sgn <= Sign;
        neg_a <= A[WIDTH-1];
        neg_b <= B[WIDTH-1];
        bz <= B == '0;
        rem <= '0;
        // on divide-by-zero quo carries the raw dividend through to Hi
        quo <= B == '0 ? A : mag_a;
        dvs <= mag_b;
        cnt <= '0;
        div_zero <= 1'b0;
      end else if (state == RUN && !cancel) begin
        rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        cnt <= cnt + 1'b1;
      end else if (state == FIX && !cancel) begin
        done <= 1'b1;
        div_zero <= bz;
        Lo <= bz ? '1 : (sgn && (neg_a ^ neg_b) ? -quo : quo);
        Hi <= bz ? quo : (sgn && neg_a ? -rem : rem);
      end
    end
endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: directed checks of mdu_divider results, latency, handshake and abort
module tb_mdu_divider;
  logic clk = 1'b0;
  logic rst_n, start, Sign, cancel, busy, done, div_zero;
  logic [31:0] A, B, Hi, Lo;
  int nt = 0;
  int nf = 0;
  mdu_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Sign(Sign), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero), .Hi(Hi), .Lo(Lo)
  );
  always #5 clk = ~clk;
  task automatic wait_done(output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat, output int bcnt);
    @(negedge clk);
    A = a;
    B = b;
    Sign = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
  endtask
  task automatic test_reset;
    nt++; if (busy !== 1'b0) begin nf++; $display("FAIL reset_busy got %b want 0", busy); end
    nt++; if (done !== 1'b0) begin nf++; $display("FAIL reset_done got %b want 0", done); end
    nt++; if (div_zero !== 1'b0) begin nf++; $display("FAIL reset_dz got %b want 0", div_zero); end
    nt++; if (Hi !== 32'h0 || Lo !== 32'h0) begin nf++; $display("FAIL reset_hilo got %h/%h want 0/0", Hi, Lo); end
  endtask
  task automatic test_unsigned;
    int lat, bc;
    run_op(32'd100, 32'd7, 1'b0, lat, bc);
    nt++; if (lat !== 34) begin nf++; $display("FAIL u100_7_latency got %0d want 34", lat); end
    nt++; if (bc !== 33) begin nf++; $display("FAIL u100_7_busy got %0d want 33", bc); end
    nt++; if (Lo !== 32'd14 || Hi !== 32'd2) begin nf++; $display("FAIL u100_7 got Lo=%h Hi=%h want 0000000e/00000002", Lo, Hi); end
    nt++; if (div_zero !== 1'b0) begin nf++; $display("FAIL u100_7_dz got %b want 0", div_zero); end
    run_op(32'hFFFFFFFF, 32'h80000001, 1'b0, lat, bc);
    nt++; if (Lo !== 32'd1 || Hi !== 32'h7FFFFFFE) begin nf++; $display("FAIL u_bigdiv got Lo=%h Hi=%h want 00000001/7ffffffe", Lo, Hi); end
  endtask
  task automatic test_signed;
    int lat, bc;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, lat, bc);
    nt++; if (Lo !== 32'hFFFFFFFD || Hi !== 32'hFFFFFFFF) begin nf++; $display("FAIL s_m7_2 got Lo=%h Hi=%h want fffffffd/ffffffff", Lo, Hi); end
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, lat, bc);
    nt++; if (Lo !== 32'hFFFFFFFD || Hi !== 32'd1) begin nf++; $display("FAIL s_7_m2 got Lo=%h Hi=%h want fffffffd/00000001", Lo, Hi); end
    nt++; if (lat !== 34) begin nf++; $display("FAIL s_7_m2_latency got %0d want 34", lat); end
    run_op(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, lat, bc);
    nt++; if (Lo !== 32'd3 || Hi !== 32'hFFFFFFFF) begin nf++; $display("FAIL s_m7_m2 got Lo=%h Hi=%h want 00000003/ffffffff", Lo, Hi); end
  endtask
  task automatic test_overflow;
    int lat, bc;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bc);
    nt++; if (Lo !== 32'h80000000 || Hi !== 32'h0) begin nf++; $display("FAIL s_overflow got Lo=%h Hi=%h want 80000000/00000000", Lo, Hi); end
    nt++; if (div_zero !== 1'b0) begin nf++; $display("FAIL s_overflow_dz got %b want 0", div_zero); end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc);
    nt++; if (Lo !== 32'h0 || Hi !== 32'h80000000) begin nf++; $display("FAIL u_large got Lo=%h Hi=%h want 00000000/80000000", Lo, Hi); end
  endtask
  task automatic test_div_zero;
    int lat, bc;
    run_op(32'h12345678, 32'h0, 1'b1, lat, bc);
    nt++; if (lat !== 2) begin nf++; $display("FAIL dz_latency got %0d want 2", lat); end
    nt++; if (Lo !== 32'hFFFFFFFF || Hi !== 32'h12345678) begin nf++; $display("FAIL dz_result got Lo=%h Hi=%h want ffffffff/12345678", Lo, Hi); end
    nt++; if (div_zero !== 1'b1) begin nf++; $display("FAIL dz_flag got %b want 1", div_zero); end
    @(negedge clk);
    nt++; if (div_zero !== 1'b1) begin nf++; $display("FAIL dz_hold got %b want 1", div_zero); end
    A = 32'd9;
    B = 32'd3;
    Sign = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nt++; if (div_zero !== 1'b0) begin nf++; $display("FAIL dz_clear got %b want 0", div_zero); end
    wait_done(lat, bc);
    nt++; if (Lo !== 32'd3 || Hi !== 32'd0) begin nf++; $display("FAIL dz_next got Lo=%h Hi=%h want 00000003/00000000", Lo, Hi); end
  endtask
  task automatic test_start_ignored;
    int lat = -1;
    @(negedge clk);
    A = 32'd1000;
    B = 32'd10;
    Sign = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (n == 10) begin
        A = 32'd5;
        B = 32'd5;
        start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    nt++; if (lat !== 34) begin nf++; $display("FAIL ignored_latency got %0d want 34", lat); end
    nt++; if (Lo !== 32'd100 || Hi !== 32'd0) begin nf++; $display("FAIL ignored_result got Lo=%h Hi=%h want 00000064/00000000", Lo, Hi); end
  endtask
  task automatic test_back_to_back;
    int lat, bc;
    run_op(32'd100, 32'd7, 1'b0, lat, bc);
    nt++; if (Lo !== 32'd14 || Hi !== 32'd2) begin nf++; $display("FAIL b2b_first got Lo=%h Hi=%h want 0000000e/00000002", Lo, Hi); end
    A = 32'd50;
    B = 32'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nt++; if (busy !== 1'b1) begin nf++; $display("FAIL b2b_busy got %b want 1", busy); end
    wait_done(lat, bc);
    nt++; if (lat !== 34) begin nf++; $display("FAIL b2b_latency got %0d want 34", lat); end
    nt++; if (Lo !== 32'd8 || Hi !== 32'd2) begin nf++; $display("FAIL b2b_second got Lo=%h Hi=%h want 00000008/00000002", Lo, Hi); end
  endtask
  task automatic test_cancel;
    logic seen = 1'b0;
    @(negedge clk);
    A = 32'd1000;
    B = 32'd7;
    Sign = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    nt++; if (busy !== 1'b0 || done !== 1'b0) begin nf++; $display("FAIL cancel_run got busy=%b done=%b want 0/0", busy, done); end
    for (int n = 0; n < 40; n++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    nt++; if (seen !== 1'b0) begin nf++; $display("FAIL cancel_nodone got %b want 0", seen); end
    nt++; if (Lo !== 32'd8 || Hi !== 32'd2) begin nf++; $display("FAIL cancel_hold got Lo=%h Hi=%h want 00000008/00000002", Lo, Hi); end
    start = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b0;
    nt++; if (busy !== 1'b0) begin nf++; $display("FAIL cancel_idle got busy=%b want 0", busy); end
    A = 32'h55;
    B = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    nt++; if (done !== 1'b0 || busy !== 1'b0) begin nf++; $display("FAIL cancel_fix got done=%b busy=%b want 0/0", done, busy); end
    nt++; if (Lo !== 32'd8 || Hi !== 32'd2 || div_zero !== 1'b0) begin nf++; $display("FAIL cancel_fix_hold got Lo=%h Hi=%h dz=%b want 00000008/00000002/0", Lo, Hi, div_zero); end
  endtask
  task automatic test_reset_mid;
    int lat, bc;
    @(negedge clk);
    A = 32'd1000;
    B = 32'd7;
    Sign = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nt++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
      nf++; $display("FAIL reset_mid got busy=%b done=%b dz=%b Hi=%h Lo=%h want all 0", busy, done, div_zero, Hi, Lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, lat, bc);
    nt++; if (lat !== 34 || Lo !== 32'd3 || Hi !== 32'd0) begin nf++; $display("FAIL reset_fresh got lat=%0d Lo=%h Hi=%h want 34/00000003/00000000", lat, Lo, Hi); end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cancel = 1'b0;
    Sign = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_unsigned;
    test_signed;
    test_overflow;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_cancel;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
